// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the register file
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;
    localparam int ZERO_IDX      = 0;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - write port plus two read ports of the register file
interface reg_file_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);

    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;

    modport master (
        output clr, we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  clr, we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );

endinterface

// File: rtl/reg_word.sv
// rtl/reg_word.sv - one storage word with async reset, sync clear and load enable
module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (load) begin
            val_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - DEPTH x WIDTH register file, one write port, two async read ports
// Optional write-through forwarding enabled by REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] word_val [DEPTH];
    logic             write_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Out-of-range addresses and the hardwired zero register never accept data.
    always_comb begin
        write_ok = bus.we && (32'(bus.waddr) < DEPTH);
        if ((ZERO_REG != 0) && (bus.waddr == ADDR_W'(ZERO_IDX))) begin
            write_ok = 1'b0;
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (write_ok && (bus.waddr == ADDR_W'(i))) begin
                load[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk  (clk),
            .rst  (rst),
            .clr  (bus.clr),
            .load (load[g]),
            .d    (bus.wdata),
            .q    (word_val[g])
        );
    end

    // Unmatched addresses (>= DEPTH) fall through to zero.
    function automatic logic [WIDTH-1:0] read_word(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                r = word_val[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        rd_a = read_word(bus.raddr_a);
        rd_b = read_word(bus.raddr_b);
`ifdef REG_FILE_BYPASS_EN
        if (write_ok && !bus.clr && !rst) begin
            if (bus.raddr_a == bus.waddr) begin
                rd_a = bus.wdata;
            end
            if (bus.raddr_b == bus.waddr) begin
                rd_b = bus.wdata;
            end
        end
`endif
    end

    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;

endmodule
